// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Register hazard scoreboard for an in-order pipeline. Every architectural
// register has a small pending counter that holds the number of cycles until
// its in-flight result can be forwarded. Each cycle the block checks the decode
// stage's source operands against those counters. If a source is still pending,
// it stalls fetch/decode and inserts a bubble into execute.
//
// Ports
//   Clk        : single clock, all state updates on the rising edge
//   Reset      : synchronous, active-low reset
//   IssueValid : decode presents an instruction this cycle
//   SrcA/SrcB  : source register addresses (ADDR_W bits each)
//   SrcAUsed   : instruction reads SrcA
//   SrcBUsed   : instruction reads SrcB
//   Dst        : destination register address
//   DstWrite   : instruction writes Dst
//   DstLat     : cycles until the Dst result is forwardable (0 -> 1, clamped to MAX_LAT)
//   Flush      : squash the instruction in decode this cycle
//   Stall      : hold fetch/decode, bubble into execute
//   HazardType : {SrcB hazard, SrcA hazard}
//   Busy       : bit i set while register i has a pending result
//   StallCount : saturating count of cycles with Stall high
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   SrcA,
  input  logic [ADDR_W-1:0]   SrcB,
  input  logic                SrcAUsed,
  input  logic                SrcBUsed,
  input  logic [ADDR_W-1:0]   Dst,
  input  logic                DstWrite,
  input  logic [2:0]          DstLat,
  input  logic                Flush,
  output logic                Stall,
  output logic [1:0]          HazardType,
  output logic [NUM_REGS-1:0] Busy,
  output logic [CNT_W-1:0]    StallCount
);

  logic [2:0] pend [NUM_REGS];

  logic hazA;
  logic hazB;
  logic issueAccept;
  logic allocate;
  logic [2:0] effLat;

  // Busy is derived from the pending counters.
  always_comb begin
    Busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      Busy[i] = (pend[i] != 3'd0);
    end
  end

  // Register 0 is never tracked, so a zero source address can never hazard.
  // The checks use the pre-update counters. Because of that, an instruction
  // whose source equals its own destination does not stall on itself.
  always_comb begin
    hazA = IssueValid & SrcAUsed & (SrcA != '0) & Busy[SrcA];
    hazB = IssueValid & SrcBUsed & (SrcB != '0) & Busy[SrcB];
  end

  // Flush dominates the stall. A squashed instruction is never held and never
  // allocates. HazardType still reports what the operands collided with.
  always_comb begin
    HazardType  = {hazB, hazA};
    Stall       = (hazA | hazB) & ~Flush;
    issueAccept = IssueValid & ~Stall & ~Flush;
    allocate    = issueAccept & DstWrite & (Dst != '0);
  end

  // A zero latency means "next cycle", the same as an ALU result.
  // Latencies beyond the deepest pipeline are clamped.
  always_comb begin
    if (DstLat == 3'd0) begin
      effLat = 3'd1;
    end else if (DstLat > 3'(MAX_LAT)) begin
      effLat = 3'(MAX_LAT);
    end else begin
      effLat = DstLat;
    end
  end

  // Every nonzero counter counts down once per cycle. A new allocation
  // replaces that count, which also covers WAW overwrites of a busy register.
  // Entry 0 is pinned to zero.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          pend[i] <= 3'd0;
        end else if (allocate && (Dst == ADDR_W'(i))) begin
          pend[i] <= effLat;
        end else if (pend[i] != 3'd0) begin
          pend[i] <= pend[i] - 3'd1;
        end
      end
    end
  end

  // The statistics counter sticks at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule
